// File: rtl/wb_write_buffer_if.sv
// Wishbone classic bundle shared by the write buffer's upstream and downstream ports.
// dat_m travels master-to-slave and dat_s travels slave-to-master.
interface if_wb #(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32
);
    logic [AWIDTH-1:0]   adr;
    logic [DWIDTH-1:0]   dat_m;
    logic [DWIDTH-1:0]   dat_s;
    logic [DWIDTH/8-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
    logic                ack;

    modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack);
    modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack);
endinterface

// File: rtl/wb_write_buffer.sv
// Posted-write buffer between a Wishbone arbiter and a memory port.
// Define WBUF_READ_BYPASS_EN to let reads overtake buffered writes to other addresses.
module wb_write_buffer #(
    parameter int AWIDTH = 26,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    if_wb.slave                      inbus,
    if_wb.master                     outbus,
    output logic [$clog2(DEPTH):0]   wbuf_count,
    output logic                     wbuf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DWIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [AWIDTH-1:0] adr_mem [DEPTH];
    logic [DWIDTH-1:0] dat_mem [DEPTH];
    logic [SW-1:0]     sel_mem [DEPTH];

    logic              ack_q;
    logic [DWIDTH-1:0] dat_s_q;
    logic              rd_abort;
    logic              o_cyc;
    logic              o_we;
    logic [AWIDTH-1:0] o_adr;
    logic [DWIDTH-1:0] o_dat;
    logic [SW-1:0]     o_sel;

    logic              wr_req;
    logic              rd_req;
    logic              capture;
    logic              pop;
    logic              read_ok;

    // The master keeps stb high during our ack cycle, so ack_q masks that cycle.
    always_comb begin
        wr_req  = inbus.cyc & inbus.stb & inbus.we & ~ack_q;
        rd_req  = inbus.cyc & inbus.stb & ~inbus.we & ~ack_q;
        capture = wr_req & (count < CW'(DEPTH));
        pop     = (state == WRITE) & outbus.ack;
    end

`ifdef WBUF_READ_BYPASS_EN
    // A read may go ahead only if no buffered write targets the same word.
    always_comb begin
        logic          addr_hit;
        logic [PW-1:0] offs;
        addr_hit = 1'b0;
        offs     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if (({1'b0, offs} < count) && (adr_mem[i] == inbus.adr))
                addr_hit = 1'b1;
        end
        read_ok = ~addr_hit;
    end
`else
    assign read_ok = (count == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (capture) begin
            adr_mem[tail] <= inbus.adr;
            dat_mem[tail] <= inbus.dat_m;
            sel_mem[tail] <= inbus.sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ack_q    <= 1'b0;
            dat_s_q  <= '0;
            rd_abort <= 1'b0;
            o_cyc    <= 1'b0;
            o_we     <= 1'b0;
            o_adr    <= '0;
            o_dat    <= '0;
            o_sel    <= '0;
        end else begin
            ack_q <= capture;
            if (capture)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + CW'(capture) - CW'(pop);

            case (state)
                IDLE: begin
                    if (rd_req && read_ok) begin
                        state    <= READ;
                        o_cyc    <= 1'b1;
                        o_we     <= 1'b0;
                        o_adr    <= inbus.adr;
                        o_sel    <= inbus.sel;
                        rd_abort <= 1'b0;
                    end else if (count != '0) begin
                        state <= WRITE;
                        o_cyc <= 1'b1;
                        o_we  <= 1'b1;
                        o_adr <= adr_mem[head];
                        o_dat <= dat_mem[head];
                        o_sel <= sel_mem[head];
                    end
                end
                WRITE: begin
                    if (outbus.ack) begin
                        state <= IDLE;
                        o_cyc <= 1'b0;
                        o_we  <= 1'b0;
                    end
                end
                READ: begin
                    // Once the requester gives up, the downstream read still finishes silently.
                    if (!inbus.cyc)
                        rd_abort <= 1'b1;
                    if (outbus.ack) begin
                        state <= IDLE;
                        o_cyc <= 1'b0;
                        o_we  <= 1'b0;
                        if (inbus.cyc && !rd_abort) begin
                            dat_s_q <= outbus.dat_s;
                            ack_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    o_cyc <= 1'b0;
                    o_we  <= 1'b0;
                end
            endcase
        end
    end

    assign inbus.ack    = ack_q;
    assign inbus.dat_s  = dat_s_q;
    assign outbus.cyc   = o_cyc;
    assign outbus.stb   = o_cyc;
    assign outbus.we    = o_we;
    assign outbus.adr   = o_adr;
    assign outbus.dat_m = o_dat;
    assign outbus.sel   = o_sel;
    assign wbuf_count   = count;
    assign wbuf_empty   = (count == '0);
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: posting, back-pressure, draining, read ordering and reset.
module tb_wb_write_buffer;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [2:0] wbuf_count;
    logic       wbuf_empty;

    if_wb #(.AWIDTH(26), .DWIDTH(32)) inbus ();
    if_wb #(.AWIDTH(26), .DWIDTH(32)) outbus ();

    wb_write_buffer #(.AWIDTH(26), .DWIDTH(32), .DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inbus      (inbus),
        .outbus     (outbus),
        .wbuf_count (wbuf_count),
        .wbuf_empty (wbuf_empty)
    );

    always #5 clk_i = ~clk_i;

    int nChecks = 0;
    int nBad    = 0;
    int maxCount = 0;

    bit          dsHold  = 1'b1;
    int          dsWait  = 0;
    int          dsCnt   = 0;
    logic [31:0] dsRdata = 32'h0;
    logic [25:0] logAdr [$];
    logic [31:0] logDat [$];
    logic [3:0]  logSel [$];
    logic        logWe  [$];

    // Downstream slave: acks after dsWait cycles unless held, and logs every acked access.
    initial begin
        outbus.ack   = 1'b0;
        outbus.dat_s = 32'h0;
        forever begin
            @(posedge clk_i);
            #1;
            if (outbus.ack) begin
                outbus.ack = 1'b0;
            end else if (outbus.cyc && outbus.stb && !dsHold) begin
                if (dsCnt >= dsWait) begin
                    outbus.ack   = 1'b1;
                    outbus.dat_s = dsRdata;
                    logAdr.push_back(outbus.adr);
                    logDat.push_back(outbus.dat_m);
                    logSel.push_back(outbus.sel);
                    logWe.push_back(outbus.we);
                    dsCnt = 0;
                end else begin
                    dsCnt++;
                end
            end else begin
                dsCnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (int'(wbuf_count) > maxCount) maxCount = int'(wbuf_count);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [25:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        inbus.cyc   = c;
        inbus.stb   = c;
        inbus.we    = w;
        inbus.adr   = a;
        inbus.dat_m = d;
        inbus.sel   = s;
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        logAdr.delete();
        logDat.delete();
        logSel.delete();
        logWe.delete();
    endtask

    task automatic waitCycles(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (inbus.ack) acks++;
        end
    endtask

    task automatic waitAck(input string tag, input int budget, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        while (!got && waits < budget) begin
            @(negedge clk_i);
            waits++;
            if (inbus.ack) got = 1'b1;
        end
        if (!got) checkOutput(tag, 64'd0, 64'd1);
    endtask

    task automatic busWrite(input logic [25:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int waits);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, a, d, s);
        waitAck("wr_timeout", 50, waits);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic waitDrained(input int budget);
        int n;
        n = 0;
        while ((wbuf_count != 0 || outbus.cyc) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int          waits;
        int          acks;
        logic [3:0]  sels [5];
        logic [25:0] expAdr [4];
        logic        expWe  [4];

        sels[0] = 4'hF; sels[1] = 4'h1; sels[2] = 4'h3; sels[3] = 4'hC; sels[4] = 4'h8;

        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_count", wbuf_count, 0);
        checkOutput("rst_empty", wbuf_empty, 1);
        checkOutput("rst_out_cyc", outbus.cyc, 0);
        checkOutput("rst_in_ack", inbus.ack, 0);
        checkOutput("rst_dat_s", inbus.dat_s, 0);
        rst_i = 1'b1;

        // Fill the buffer while downstream stalls, then push a fifth write against a full FIFO.
        dsHold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            busWrite(26'h10 + 26'(i), 32'hA5A50000 + 32'(i), sels[i], waits);
            checkOutput($sformatf("fill_ack_lat%0d", i), waits, 1);
        end
        checkOutput("fill_count", wbuf_count, 4);
        checkOutput("fill_empty", wbuf_empty, 0);
        checkOutput("fill_out_cyc", outbus.cyc, 1);
        checkOutput("fill_out_we", outbus.we, 1);
        checkOutput("fill_out_adr", outbus.adr, 26'h10);

        @(negedge clk_i);
        applyStimulus(1'b1, 1'b1, 26'h14, 32'hA5A50004, sels[4]);
        waitCycles(4, acks);
        checkOutput("full_no_ack", acks, 0);
        checkOutput("full_count", wbuf_count, 4);

        dsWait = 0;
        dsHold = 1'b0;
        @(negedge clk_i);
        dsHold = 1'b1;
        @(negedge clk_i);
        checkOutput("pop_count", wbuf_count, 3);
        checkOutput("pop_no_ack", inbus.ack, 0);
        @(negedge clk_i);
        checkOutput("refill_count", wbuf_count, 4);
        checkOutput("refill_ack", inbus.ack, 1);
        checkOutput("next_head_adr", outbus.adr, 26'h11);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        dsWait = 3;
        dsHold = 1'b0;
        waitDrained(300);
        checkOutput("drain_n", logAdr.size(), 5);
        if (logAdr.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("drain_adr%0d", i), logAdr[i], 26'h10 + 26'(i));
                checkOutput($sformatf("drain_dat%0d", i), logDat[i], 32'hA5A50000 + 32'(i));
                checkOutput($sformatf("drain_sel%0d", i), logSel[i], sels[i]);
            end
        end
        checkOutput("drain_empty", wbuf_empty, 1);
        checkOutput("max_count", maxCount, 4);

        // A read to a buffered address must wait for that write to reach memory.
        doReset();
        dsHold = 1'b1;
        busWrite(26'h20, 32'hDEADBEEF, 4'hF, waits);
        checkOutput("raw_wr_lat", waits, 1);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 26'h20, '0, 4'hF);
        waitCycles(4, acks);
        checkOutput("raw_wait_ack", acks, 0);
        checkOutput("raw_wait_we", outbus.we, 1);
        dsRdata = 32'hCAFEF00D;
        dsWait  = 1;
        dsHold  = 1'b0;
        waitAck("raw_rd_timeout", 50, waits);
        checkOutput("raw_dat_s", inbus.dat_s, 32'hCAFEF00D);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("raw_log_n", logAdr.size(), 2);
        if (logAdr.size() == 2) begin
            checkOutput("raw_first_we", logWe[0], 1);
            checkOutput("raw_first_dat", logDat[0], 32'hDEADBEEF);
            checkOutput("raw_second_we", logWe[1], 0);
            checkOutput("raw_second_adr", logAdr[1], 26'h20);
        end

        // Read to an unrelated address behind three buffered writes.
        doReset();
        dsHold = 1'b1;
        for (int i = 0; i < 3; i++) busWrite(26'h30 + 26'(i), 32'h300 + 32'(i), 4'hF, waits);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 26'h40, '0, 4'hF);
        waitCycles(3, acks);
        dsRdata = 32'h40404040;
        dsWait  = 0;
        dsHold  = 1'b0;
        waitAck("ord_rd_timeout", 100, waits);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        waitDrained(100);
`ifdef WBUF_READ_BYPASS_EN
        expAdr[0] = 26'h30; expAdr[1] = 26'h40; expAdr[2] = 26'h31; expAdr[3] = 26'h32;
        expWe[0]  = 1'b1;   expWe[1]  = 1'b0;   expWe[2]  = 1'b1;   expWe[3]  = 1'b1;
`else
        expAdr[0] = 26'h30; expAdr[1] = 26'h31; expAdr[2] = 26'h32; expAdr[3] = 26'h40;
        expWe[0]  = 1'b1;   expWe[1]  = 1'b1;   expWe[2]  = 1'b1;   expWe[3]  = 1'b0;
`endif
        checkOutput("ord_log_n", logAdr.size(), 4);
        if (logAdr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("ord_adr%0d", i), logAdr[i], expAdr[i]);
                checkOutput($sformatf("ord_we%0d", i), logWe[i], expWe[i]);
            end
        end

        // A read matching the newest buffered write waits until the FIFO empties.
        doReset();
        dsHold = 1'b1;
        for (int i = 0; i < 3; i++) busWrite(26'h30 + 26'(i), 32'h300 + 32'(i), 4'hF, waits);
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 26'h32, '0, 4'hF);
        waitCycles(3, acks);
        dsHold = 1'b0;
        waitAck("hit_rd_timeout", 100, waits);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("hit_log_n", logAdr.size(), 4);
        if (logAdr.size() == 4) begin
            checkOutput("hit_last_we", logWe[3], 0);
            checkOutput("hit_prev_adr", logAdr[2], 26'h32);
            checkOutput("hit_prev_we", logWe[2], 1);
        end

        // Requester abandons a read that is already downstream.
        doReset();
        dsHold = 1'b1;
        @(negedge clk_i);
        applyStimulus(1'b1, 1'b0, 26'h50, '0, 4'h3);
        waitCycles(2, acks);
        checkOutput("abort_out_cyc", outbus.cyc, 1);
        checkOutput("abort_out_we", outbus.we, 0);
        checkOutput("abort_out_adr", outbus.adr, 26'h50);
        checkOutput("abort_out_sel", outbus.sel, 4'h3);
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk_i);
        dsHold = 1'b0;
        waitCycles(5, acks);
        checkOutput("abort_no_ack", acks, 0);
        checkOutput("abort_done_cyc", outbus.cyc, 0);
        checkOutput("abort_log_n", logAdr.size(), 1);

        // Reset pulse in the middle of a stalled write with three entries buffered.
        doReset();
        dsHold = 1'b1;
        for (int i = 0; i < 3; i++) busWrite(26'h60 + 26'(i), 32'h600 + 32'(i), 4'hF, waits);
        checkOutput("mid_count", wbuf_count, 3);
        checkOutput("mid_cyc", outbus.cyc, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        checkOutput("mid_rst_count", wbuf_count, 0);
        checkOutput("mid_rst_cyc", outbus.cyc, 0);
        checkOutput("mid_rst_empty", wbuf_empty, 1);
        checkOutput("mid_rst_ack", inbus.ack, 0);
        dsHold = 1'b0;
        waitCycles(5, acks);
        checkOutput("mid_rst_no_ack", acks, 0);
        checkOutput("mid_rst_log_n", logAdr.size(), 0);
        checkOutput("mid_rst_count2", wbuf_count, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end
endmodule
